maxpool_stream_y: RTL

//  Downstream stage of the conv output stream: consumes the signed y vector (LENY values per frame)

---
 rtl/maxpool_stream_y.sv | 125 ++++++++++++
 1 files changed

// File: rtl/maxpool_stream_y.sv
// -----------------------------------------------------------------------------
// maxpool_stream_y
//
// Streaming 1-D max-pool stage for the signed conv output vector y.
// Each frame carries LENY samples; the stage emits the signed maximum of every
// non-overlapping POOL-wide window (stride == POOL). When LENY is not a
// multiple of POOL, the trailing partial window emits its own maximum. Frames
// run back-to-back. The output is a single registered entry, and no frame-level
// buffering is kept.
//
// Parameters
//   WIDTH : sample width, signed two's complement (input and output)
//   LENY  : samples per input frame
//   POOL  : window size and stride, 1..LENY
//
// Ports
//   clk           in   1      clock, all state on posedge
//   reset         in   1      asynchronous active-low reset
//   s_data_in_y   in   WIDTH  signed input sample
//   s_valid_y     in   1      input valid
//   s_ready_y     out  1      input ready (combinational from m_ready_z)
//   m_data_out_z  out  WIDTH  signed pooled output (registered)
//   m_valid_z     out  1      output valid
//   m_ready_z     in   1      output ready
//   m_last_z      out  1      last pooled output of a frame
//
// Configuration
//   MAXPOOL_LAST_EN : when defined, m_last_z is registered alongside
//                     m_data_out_z and marks the window that closed at the
//                     final frame position. When undefined, m_last_z is tied 0.
// -----------------------------------------------------------------------------
module maxpool_stream_y #(
    parameter int WIDTH = 8,
    parameter int LENY  = 5,
    parameter int POOL  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [WIDTH-1:0] m_data_out_z,
    output logic                    m_valid_z,
    input  logic                    m_ready_z,
    output logic                    m_last_z
);

    localparam int WC_W = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int PS_W = (LENY > 1) ? $clog2(LENY) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(POOL - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(LENY - 1);

    // Ties return the running value, so an equal newcomer never replaces it.
    function automatic logic signed [WIDTH-1:0] max_signed(
        input logic signed [WIDTH-1:0] run,
        input logic signed [WIDTH-1:0] nxt
    );
        return (nxt > run) ? nxt : run;
    endfunction

    logic signed [WIDTH-1:0] acc;
    logic [WC_W-1:0]         win_cnt;
    logic [PS_W-1:0]         pos;

    logic                    accept;
    logic                    frame_end;
    logic                    close;
    logic signed [WIDTH-1:0] cand;

    // The slot can take a new value whenever it is empty or being drained now.
    assign s_ready_y = !m_valid_z || m_ready_z;

    // ---- stage 0: window compare on the incoming sample ----
    always_comb begin
        accept    = s_valid_y && s_ready_y;
        frame_end = (pos == PS_LAST);
        close     = (win_cnt == WC_LAST) || frame_end;
        cand      = (win_cnt == '0) ? s_data_in_y : max_signed(acc, s_data_in_y);
    end

    // ---- stage 1: window state and registered output slot ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            win_cnt      <= '0;
            pos          <= '0;
            m_data_out_z <= '0;
            m_valid_z    <= 1'b0;
        end else begin
            if (accept) begin
                // The frame boundary also closes the window, so win_cnt restarts
                // at the same time as pos.
                pos <= frame_end ? '0 : pos + PS_W'(1);
                if (close) begin
                    m_data_out_z <= cand;
                    acc          <= '0;
                    win_cnt      <= '0;
                end else begin
                    acc     <= cand;
                    win_cnt <= win_cnt + WC_W'(1);
                end
            end
            // A closing accept refills the slot even while it drains, which
            // keeps full throughput. Without one, a taken output empties it.
            if (accept && close) begin
                m_valid_z <= 1'b1;
            end else if (m_ready_z) begin
                m_valid_z <= 1'b0;
            end
        end
    end

`ifdef MAXPOOL_LAST_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_last_z <= 1'b0;
        end else if (accept && close) begin
            m_last_z <= frame_end;
        end
    end
`else
    assign m_last_z = 1'b0;
`endif

endmodule
